// File: rtl/heartbeat_pkg.sv
// Shared types and constant helpers for the heartbeat monitor.
// Contents:
//   uint_32        - 32-bit unsigned integer type used for parameters
//   state_t        - monitor state encoding
//   calc_p_min/max - acceptance window limits, evaluated once at elaboration
package heartbeat_pkg;

  typedef int unsigned uint_32;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED,
    LOST
  } state_t;

  // Nominal period minus tolerance, clamped at zero.
  function automatic uint_32 calc_p_min(input uint_32 clk_hz, input uint_32 hb_hz,
                                        input uint_32 tol);
    uint_32 p;
    p = clk_hz / hb_hz;
    return (p > tol) ? (p - tol) : 32'd0;
  endfunction

  // Nominal period plus tolerance, clamped at the 32-bit maximum.
  function automatic uint_32 calc_p_max(input uint_32 clk_hz, input uint_32 hb_hz,
                                        input uint_32 tol);
    logic [32:0] sum;
    sum = 33'(clk_hz / hb_hz) + 33'(tol);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a registered edge detector.
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   d            - asynchronous input
//   level        - synchronised level, aligned with the rise/fall pulses
//   rise, fall   - one-cycle registered pulses on level transitions
// An input change before edge n shows up on rise/fall in cycle n+2.
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // stage 0/1: metastability filter
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      // stage 2: edge pulses and the level they refer to
      level   <= sync_p1;
      rise    <= sync_p1 & ~level;
      fall    <= ~sync_p1 & level;
    end
  end

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat receiver: measures period and high time of an asynchronous
// heartbeat and qualifies the period against a nominal window.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   i_heartbeat   - asynchronous heartbeat input
//   o_locked      - high while LOCKED
//   o_lost        - high while LOST
//   o_period_err  - one-cycle pulse on an out-of-window period
//   o_valid       - one-cycle pulse when o_period is updated
//   o_period      - last measured period in cycles
//   o_high        - last measured high time in cycles
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter uint_32 CLK_HZ       = 12_000_000,
  parameter uint_32 HB_HZ        = 1,
  parameter uint_32 TOL_CNTS     = CLK_HZ / HB_HZ / 100,
  parameter uint_32 TIMEOUT_CNTS = 2 * CLK_HZ / HB_HZ,
  parameter uint_32 LOCK_COUNT   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_heartbeat,
  output logic        o_locked,
  output logic        o_lost,
  output logic        o_period_err,
  output logic        o_valid,
  output logic [31:0] o_period,
  output logic [31:0] o_high
);

  localparam uint_32 P_MIN = calc_p_min(CLK_HZ, HB_HZ, TOL_CNTS);
  localparam uint_32 P_MAX = calc_p_max(CLK_HZ, HB_HZ, TOL_CNTS);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        level;
  logic        rise;
  logic        fall;
  logic [31:0] cnt;
  logic [31:0] hcnt;
  logic [31:0] good;
  logic [31:0] good_nxt;
  logic [31:0] good_inc;
  state_t      state;
  state_t      state_nxt;
  logic        valid_nxt;
  logic        err_nxt;
  logic        in_win;
  logic        timeout;

  sync_edge_detect u_sync (
    .clock (clock),
    .reset (reset),
    .d     (i_heartbeat),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign in_win   = (cnt >= P_MIN) && (cnt <= P_MAX);
  assign timeout  = (cnt >= TIMEOUT_CNTS);
  assign good_inc = good + 32'd1;

  // Rise is checked first in every state, so it wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      SEARCH: begin
        if (rise) begin
          state_nxt = ACQUIRE;
          good_nxt  = 32'd0;
        end else if (timeout) begin
          state_nxt = LOST;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          valid_nxt = 1'b1;
          if (in_win) begin
            good_nxt = good_inc;
            if (good_inc >= LOCK_COUNT) state_nxt = LOCKED;
          end else begin
            good_nxt = 32'd0;
            err_nxt  = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = LOST;
        end
      end
      LOCKED: begin
        if (rise) begin
          valid_nxt = 1'b1;
          if (!in_win) begin
            err_nxt   = 1'b1;
            good_nxt  = 32'd0;
            state_nxt = ACQUIRE;
          end
        end else if (timeout) begin
          state_nxt = LOST;
        end
      end
      LOST: begin
        // The count since the last edge is stale here, so it is not judged.
        if (rise) begin
          state_nxt = ACQUIRE;
          good_nxt  = 32'd0;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= SEARCH;
      good         <= 32'd0;
      cnt          <= 32'd0;
      hcnt         <= 32'd0;
      o_locked     <= 1'b0;
      o_lost       <= 1'b0;
      o_period_err <= 1'b0;
      o_valid      <= 1'b0;
      o_period     <= 32'd0;
      o_high       <= 32'd0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
      cnt   <= rise ? 32'd1 : sat_inc(cnt);
      if (rise)       hcnt <= 32'd1;
      else if (level) hcnt <= sat_inc(hcnt);
      if (fall)       o_high <= hcnt;
      if (valid_nxt)  o_period <= cnt;
      o_valid      <= valid_nxt;
      o_period_err <= err_nxt;
      o_locked     <= (state_nxt == LOCKED);
      o_lost       <= (state_nxt == LOST);
    end
  end

endmodule

// File: doc/heartbeat_monitor.md
# heartbeat_monitor

Receive-side counterpart to the board heartbeat generator. Samples an asynchronous heartbeat input and measures its period and high time in clock cycles. Qualifies the period against a nominal window and reports locked, lost and error status. Used wherever one clock domain or board must confirm that another is alive and running at the expected rate.

## Interface
- CLK_HZ, 12_000_000, clock frequency in Hz
- HB_HZ, 1, expected heartbeat frequency in Hz; nominal period P = CLK_HZ/HB_HZ cycles
- TOL_CNTS, CLK_HZ/HB_HZ/100, accepted period deviation in cycles; window is [P-TOL_CNTS, P+TOL_CNTS] inclusive
- TIMEOUT_CNTS, 2*CLK_HZ/HB_HZ, cycles without a rising edge before the heartbeat is declared lost
- LOCK_COUNT, 3, consecutive in-window periods required to lock
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high
- i_heartbeat  in  1  asynchronous heartbeat input
- o_locked  out  1  high while state is LOCKED
- o_lost  out  1  high while state is LOST
- o_period_err  out  1  one-cycle pulse on an out-of-window period
- o_valid  out  1  one-cycle pulse when o_period is updated
- o_period  out  32  last measured period in cycles
- o_high  out  32  last measured high time in cycles

## Operation
- **Input path.** i_heartbeat passes through a 2-flop synchroniser, then a registered edge detector. The detector produces rise and fall pulses.
- **Period counter (cnt, 32 bit, saturating at 2^32-1).**
  - Reset value is 0.
  - On a rise cycle, cnt <= 1. Otherwise cnt increments.
  - The measured period is the value of cnt on the rise cycle, which equals the number of cycles between consecutive rises.
- **High counter.**
  - Same scheme as the period counter: cleared to 1 on rise and increments while the synchronised input is high.
  - On fall, its value is captured into o_high.
- **States:** SEARCH, ACQUIRE, LOCKED, LOST. The reset state is SEARCH, with good = 0.
- **SEARCH:**
  - rise -> ACQUIRE. No period is captured because no prior edge exists.
  - cnt reaching TIMEOUT_CNTS -> LOST.
- **ACQUIRE:**
  - On rise, capture cnt into o_period and pulse o_valid.
  - If in window, increment good. When good reaches LOCK_COUNT -> LOCKED.
  - If out of window, good <= 0 and pulse o_period_err.
  - Timeout -> LOST.
- **LOCKED:**
  - In-window rise: stay in LOCKED.
  - Out-of-window rise: o_period_err pulse, good <= 0, -> ACQUIRE.
  - Timeout -> LOST.
- **LOST:**
  - rise -> ACQUIRE with good <= 0. The stale period is not evaluated and o_valid is not pulsed.
- **Simultaneous events.**
  - A rise and a timeout in the same cycle: the rise takes priority.
  - A rise and a fall cannot coincide, because of the registered detector.
- **Failure modes.** A stuck-high or stuck-low input produces no rises, so the block times out to LOST.
- **Reset mid-operation.** All state, counters and outputs clear on the next clock edge and the block returns to SEARCH.

## Timing
- Every output is registered. Reset values: o_locked 0, o_lost 0, o_period_err 0, o_valid 0, o_period 0, o_high 0.
- i_heartbeat rising before clock edge n gives a rise pulse in cycle n+2. o_valid, o_period, o_period_err and the state change are visible in cycle n+3.
- o_high updates in cycle n+3 relative to the sampled falling input.
- Timeout: the state reads LOST one cycle after cnt == TIMEOUT_CNTS. That is TIMEOUT_CNTS+1 cycles after the last rise pulse.
- Window compare is unsigned 32-bit, precomputed from constants. No runtime division.

## Structure
- Shared package heartbeat_pkg holds:
  - typedef uint_32 (int unsigned)
  - the monitor state enum (SEARCH, ACQUIRE, LOCKED, LOST)
  - helper constants P_MIN/P_MAX, derived as functions of the parameters
- One sub-module, sync_edge_detect: 2-flop synchroniser plus registered rise/fall pulses. It is reusable by other input monitors.

## Test plan
All scenarios use the overrides CLK_HZ=1000, HB_HZ=10, TOL_CNTS=2, TIMEOUT_CNTS=250, LOCK_COUNT=3, giving P=100.

- **Reset.** Assert reset for 5 cycles with the input toggling -> all outputs 0 and state SEARCH.
- **Lock.** Drive period 100 with high time 5 -> o_valid pulses on the 2nd, 3rd and 4th rise. o_locked rises 3 cycles after the 4th rise is sampled. o_period = 100 and o_high = 5.
- **Window boundaries.** While locked, apply periods of 98 and 102 -> lock is held with no error. A period of 97 -> o_period_err pulses once, o_locked drops to 0, and the block relocks after 3 further periods of 100.
- **Loss and recovery.** While locked, hold the input low -> o_lost = 1 and o_locked = 0 at 251 cycles after the last rise pulse. Resume periods of 100 -> o_lost clears on the first rise and lock follows after 3 further periods, with no o_valid on the first rise.
- **Stuck high.** Hold the input high from reset -> one rise, then LOST 251 cycles later. o_period stays 0.
- **Reset mid-lock.** Assert reset for one cycle while LOCKED -> all outputs 0 on the next cycle. Relock requires 4 fresh rises.
